// File: rtl/fb_rect_fill_if.sv
// Command and framebuffer-write bundle for fb_rect_fill.
// The master side issues fill commands and observes the VRAM write port; the slave side is the filler.
interface fb_rect_fill_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 12
) ();
    logic              cmd_valid;
    logic              cmd_ready;
    logic [9:0]        cmd_x;
    logic [8:0]        cmd_y;
    logic [9:0]        cmd_w;
    logic [8:0]        cmd_h;
    logic [DATA_W-1:0] cmd_color;
    logic              busy;
    logic              done;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] dout;

    modport master (
        output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
        input  cmd_ready, busy, done, we, addr, dout
    );

    modport slave (
        input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
        output cmd_ready, busy, done, we, addr, dout
    );
endinterface

// File: rtl/fb_rect_fill.sv
// Rectangle filler: one command per handshake, one clipped pixel write per clock in raster order.
// The first pixel is registered on the accept edge so the VRAM sees it on the very next edge.
module fb_rect_fill #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int ADDR_W = 19,
    parameter int DATA_W = 12
) (
    input  logic          clk,
    input  logic          rstn,
    fb_rect_fill_if.slave fb_if
);

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    state_t            state_q;
    logic [10:0]       x_q, x0_q, xe_q;
    logic [9:0]        y_q, ye_q;
    logic [ADDR_W-1:0] row_base_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] dout_q;
    logic              we_q, done_q, busy_q, ready_q;

    logic [10:0]       cmd_xe_sum, cmd_xe;
    logic [9:0]        cmd_ye_sum, cmd_ye;
    logic              cmd_empty;
    logic [ADDR_W-1:0] cmd_base;

    logic              x_last, y_last;
    logic [10:0]       x_d;
    logic [9:0]        y_d;
    logic [ADDR_W-1:0] row_base_d;

    // Clipped exclusive end coordinates, one bit wider than the fields so the sum cannot wrap.
    always_comb begin
        cmd_xe_sum = {1'b0, fb_if.cmd_x} + {1'b0, fb_if.cmd_w};
        cmd_ye_sum = {1'b0, fb_if.cmd_y} + {1'b0, fb_if.cmd_h};
        cmd_xe     = (cmd_xe_sum > 11'(WIDTH))  ? 11'(WIDTH)  : cmd_xe_sum;
        cmd_ye     = (cmd_ye_sum > 10'(HEIGHT)) ? 10'(HEIGHT) : cmd_ye_sum;
        cmd_empty  = (fb_if.cmd_w == '0) || (fb_if.cmd_h == '0) ||
                     ({1'b0, fb_if.cmd_x} >= 11'(WIDTH)) ||
                     ({1'b0, fb_if.cmd_y} >= 10'(HEIGHT));
        // Constant-coefficient product, only needed once per command for the starting row.
        cmd_base   = ADDR_W'(fb_if.cmd_y) * ADDR_W'(WIDTH);
    end

    // Next raster position; the row base advances by one pitch instead of re-multiplying.
    always_comb begin
        x_last     = (x_q + 11'd1) == xe_q;
        y_last     = (y_q + 10'd1) == ye_q;
        x_d        = x_q + 11'd1;
        y_d        = y_q;
        row_base_d = row_base_q;
        if (x_last) begin
            x_d        = x0_q;
            y_d        = y_q + 10'd1;
            row_base_d = row_base_q + ADDR_W'(WIDTH);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            x_q        <= '0;
            x0_q       <= '0;
            xe_q       <= '0;
            y_q        <= '0;
            ye_q       <= '0;
            row_base_q <= '0;
            addr_q     <= '0;
            dout_q     <= '0;
            we_q       <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (fb_if.cmd_valid && ready_q) begin
                        ready_q    <= 1'b0;
                        busy_q     <= 1'b1;
                        x_q        <= {1'b0, fb_if.cmd_x};
                        x0_q       <= {1'b0, fb_if.cmd_x};
                        xe_q       <= cmd_xe;
                        y_q        <= {1'b0, fb_if.cmd_y};
                        ye_q       <= cmd_ye;
                        row_base_q <= cmd_base;
                        if (cmd_empty) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            we_q    <= 1'b1;
                            addr_q  <= cmd_base + ADDR_W'(fb_if.cmd_x);
                            dout_q  <= fb_if.cmd_color;
                            state_q <= FILL;
                        end
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                FILL: begin
                    // x_q/y_q track the pixel currently on the write port.
                    if (x_last && y_last) begin
                        we_q    <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        x_q        <= x_d;
                        y_q        <= y_d;
                        row_base_q <= row_base_d;
                        addr_q     <= row_base_d + ADDR_W'(x_d);
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign fb_if.cmd_ready = ready_q;
    assign fb_if.busy      = busy_q;
    assign fb_if.done      = done_q;
    assign fb_if.we        = we_q;
    assign fb_if.addr      = addr_q;
    assign fb_if.dout      = dout_q;

endmodule
